// File: rtl/guess_judge_if.sv
// Signal bundle between the guess-judge round engine and the surrounding game logic.
// The master side drives player inputs and FSM feedback; the slave side is the judge.
interface guess_judge_if;
  logic       confirmButton;
  logic       tick_1hz;
  logic [9:0] guess;
  logic [1:0] Max_digit;
  logic [1:0] WINorLOSE;
  logic [3:0] round;
  logic [2:0] incorrect_guesses;
  logic [6:0] timer;
  logic [1:0] hint;
  logic [9:0] target;

  modport master (
    output confirmButton, tick_1hz, guess, Max_digit, WINorLOSE,
    input  round, incorrect_guesses, timer, hint, target
  );

  modport slave (
    input  confirmButton, tick_1hz, guess, Max_digit, WINorLOSE,
    output round, incorrect_guesses, timer, hint, target
  );
endinterface

// File: rtl/guess_judge.sv
// Round engine for the number-guessing game: draws the secret target, judges guesses,
// and tracks round, wrong-guess and countdown counters for the difficulty FSM.
module guess_judge #(
  parameter int T_DIFF1    = 30,
  parameter int T_DIFF2    = 60,
  parameter int T_DIFF3    = 90,
  parameter int SETTLE_CYC = 2
) (
  input logic          clk,
  input logic          restart,
  guess_judge_if.slave bus
);

  typedef enum logic [2:0] {S_LOAD, S_PLAY, S_JUDGE, S_SETTLE, S_HALT} state_t;

  state_t     state_reg, state_next;
  logic [9:0] seed_reg, seed_next;
  logic [9:0] target_reg, target_next;
  logic [9:0] guess_reg, guess_next;
  logic [3:0] round_reg, round_next;
  logic [2:0] wrong_reg, wrong_next;
  logic [6:0] timer_reg, timer_next;
  logic [1:0] hint_reg, hint_next;
  logic [7:0] settle_reg, settle_next;
  logic [1:0] md_reg;
  logic       conf_d_reg;

  logic [9:0] limit;
  logic [6:0] t_load;
  logic       conf_edge;
  logic       play_on;
  logic       settle_done;

  // Range and round length follow the difficulty; 00 behaves like 01.
  always_comb begin
    limit  = 10'd10;
    t_load = 7'(T_DIFF1);
    case (bus.Max_digit)
      2'b10: begin
        limit  = 10'd100;
        t_load = 7'(T_DIFF2);
      end
      2'b11: begin
        limit  = 10'd1000;
        t_load = 7'(T_DIFF3);
      end
      default: ;
    endcase
  end

  assign conf_edge   = bus.confirmButton & ~conf_d_reg;
  assign play_on     = (bus.WINorLOSE == 2'b11);
  assign settle_done = ({24'd0, settle_reg} + 32'd1) >= 32'(SETTLE_CYC);
  // The >= compare also pulls an out-of-range seed back when the range shrinks.
  assign seed_next   = (seed_reg >= limit - 10'd1) ? 10'd0 : seed_reg + 10'd1;

  always_ff @(posedge clk) begin
    if (restart) begin
      state_reg <= S_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LOAD:   state_next = S_PLAY;
      S_PLAY: begin
        if (!play_on)       state_next = S_HALT;
        else if (conf_edge) state_next = S_JUDGE;
      end
      S_JUDGE:  state_next = (guess_reg == target_reg) ? S_SETTLE : S_PLAY;
      S_SETTLE: begin
        if (!play_on)         state_next = S_HALT;
        else if (settle_done) state_next = S_LOAD;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_LOAD;
    endcase
  end

  always_comb begin
    target_next = target_reg;
    guess_next  = guess_reg;
    round_next  = round_reg;
    wrong_next  = wrong_reg;
    timer_next  = timer_reg;
    hint_next   = hint_reg;
    settle_next = 8'd0;
    case (state_reg)
      S_LOAD: begin
        target_next = seed_reg;
        timer_next  = t_load;
        hint_next   = 2'b00;
      end
      S_PLAY: begin
        if (bus.tick_1hz && (timer_reg != 7'd0)) timer_next = timer_reg - 7'd1;
        if (conf_edge) guess_next = bus.guess;
      end
      S_JUDGE: begin
        if (guess_reg == target_reg) begin
          hint_next  = 2'b11;
          round_next = (round_reg >= 4'd10) ? 4'd10 : round_reg + 4'd1;
        end else begin
          hint_next  = (guess_reg < target_reg) ? 2'b01 : 2'b10;
          wrong_next = (wrong_reg == 3'd7) ? 3'd7 : wrong_reg + 3'd1;
        end
      end
      S_SETTLE: settle_next = settle_reg + 8'd1;
      default: ;
    endcase
    // A difficulty change starts a fresh wrong-guess count.
    if ((state_reg != S_HALT) && (bus.Max_digit != md_reg)) wrong_next = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      seed_reg   <= 10'd0;
      target_reg <= 10'd0;
      guess_reg  <= 10'd0;
      round_reg  <= 4'd1;
      wrong_reg  <= 3'd0;
      timer_reg  <= 7'(T_DIFF1);
      hint_reg   <= 2'b00;
      settle_reg <= 8'd0;
      md_reg     <= 2'b01;
      conf_d_reg <= 1'b0;
    end else begin
      seed_reg   <= seed_next;
      target_reg <= target_next;
      guess_reg  <= guess_next;
      round_reg  <= round_next;
      wrong_reg  <= wrong_next;
      timer_reg  <= timer_next;
      hint_reg   <= hint_next;
      settle_reg <= settle_next;
      md_reg     <= bus.Max_digit;
      conf_d_reg <= bus.confirmButton;
    end
  end

  assign bus.round             = round_reg;
  assign bus.incorrect_guesses = wrong_reg;
  assign bus.timer             = timer_reg;
  assign bus.hint              = hint_reg;
  assign bus.target            = target_reg;

endmodule

// File: tb/tb_guess_judge.sv
// Directed bench for guess_judge with a registered stand-in for the difficulty FSM
// driving Max_digit from the round count.
module tb_guess_judge;
  logic       clk = 1'b0;
  logic       restart;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         seed_m = 0;
  int         lim_m;
  logic [9:0] exp_tgt;

  guess_judge_if bus ();

  guess_judge #(
    .T_DIFF1(30), .T_DIFF2(60), .T_DIFF3(90), .SETTLE_CYC(2)
  ) dut (
    .clk(clk),
    .restart(restart),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Difficulty stand-in: raises the range one cycle after round reaches 4 and 7.
  always @(posedge clk) begin
    if (bus.round >= 4'd7)      bus.Max_digit <= 2'b11;
    else if (bus.round >= 4'd4) bus.Max_digit <= 2'b10;
    else                        bus.Max_digit <= 2'b01;
  end

  // Expected free-running seed, used to know which target a LOAD will capture.
  assign lim_m = (bus.Max_digit == 2'b11) ? 1000 : (bus.Max_digit == 2'b10) ? 100 : 10;
  always @(posedge clk) begin
    if (restart)                seed_m <= 0;
    else if (seed_m >= lim_m - 1) seed_m <= 0;
    else                        seed_m <= seed_m + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    bus.WINorLOSE     = 2'b11;
    bus.confirmButton = 1'b0;
    bus.tick_1hz      = 1'b0;
    bus.guess         = 10'd0;
    restart           = 1'b1;
    step();
    step();
    restart = 1'b0;
    exp_tgt = 10'd0;
  endtask

  task automatic press(input logic [9:0] g);
    bus.guess         = g;
    bus.confirmButton = 1'b1;
    step();
    bus.confirmButton = 1'b0;
    step();
    $display("[TB] guess %0d -> hint=%b round=%0d wrong=%0d timer=%0d", g, bus.hint,
             bus.round, bus.incorrect_guesses, bus.timer);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
      step();
    end
  endtask

  // Correct guess, two settle cycles, LOAD (target latched from seed), then PLAY.
  task automatic win_round();
    press(exp_tgt);
    step();
    step();
    exp_tgt = 10'(seed_m);
    step();
  endtask

  task automatic test_reset();
    do_restart();
    tests_run++; if (bus.round !== 4'd1) begin tests_failed++; $display("FAIL reset_round got %0d want 1", bus.round); end
    tests_run++; if (bus.incorrect_guesses !== 3'd0) begin tests_failed++; $display("FAIL reset_wrong got %0d want 0", bus.incorrect_guesses); end
    tests_run++; if (bus.timer !== 7'd30) begin tests_failed++; $display("FAIL reset_timer got %0d want 30", bus.timer); end
    tests_run++; if (bus.hint !== 2'b00) begin tests_failed++; $display("FAIL reset_hint got %b want 00", bus.hint); end
    step();
    tests_run++; if (bus.target !== 10'd0) begin tests_failed++; $display("FAIL reset_target got %0d want 0", bus.target); end
    $display("[TB] reset released: round=%0d timer=%0d target=%0d", bus.round, bus.timer, bus.target);
  endtask

  task automatic test_wrong_guesses();
    // Correct guess on the first PLAY cycle lands the next LOAD on seed 5.
    bus.guess         = 10'd0;
    bus.confirmButton = 1'b1;
    step();
    bus.confirmButton = 1'b0;
    tests_run++; if (bus.hint !== 2'b00) begin tests_failed++; $display("FAIL latency_hint_early got %b want 00", bus.hint); end
    step();
    tests_run++; if (bus.hint !== 2'b11) begin tests_failed++; $display("FAIL correct_hint got %b want 11", bus.hint); end
    tests_run++; if (bus.round !== 4'd2) begin tests_failed++; $display("FAIL correct_round got %0d want 2", bus.round); end
    step();
    step();
    step();
    tests_run++; if (bus.target !== 10'd5) begin tests_failed++; $display("FAIL new_target got %0d want 5", bus.target); end
    exp_tgt = 10'd5;
    press(10'd3);
    tests_run++; if (bus.hint !== 2'b01) begin tests_failed++; $display("FAIL low_hint got %b want 01", bus.hint); end
    tests_run++; if (bus.incorrect_guesses !== 3'd1) begin tests_failed++; $display("FAIL low_wrong got %0d want 1", bus.incorrect_guesses); end
    press(10'd8);
    tests_run++; if (bus.hint !== 2'b10) begin tests_failed++; $display("FAIL high_hint got %b want 10", bus.hint); end
    tests_run++; if (bus.incorrect_guesses !== 3'd2) begin tests_failed++; $display("FAIL high_wrong got %0d want 2", bus.incorrect_guesses); end
    tests_run++; if (bus.round !== 4'd2) begin tests_failed++; $display("FAIL wrong_round got %0d want 2", bus.round); end
  endtask

  task automatic test_progression();
    win_round();
    tests_run++; if (bus.target !== 10'd4) begin tests_failed++; $display("FAIL round3_target got %0d want 4", bus.target); end
    win_round();
    tests_run++; if (bus.round !== 4'd4) begin tests_failed++; $display("FAIL prog_round got %0d want 4", bus.round); end
    tests_run++; if (bus.Max_digit !== 2'b10) begin tests_failed++; $display("FAIL prog_maxdigit got %b want 10", bus.Max_digit); end
    tests_run++; if (bus.timer !== 7'd60) begin tests_failed++; $display("FAIL prog_timer got %0d want 60", bus.timer); end
    tests_run++; if (bus.target !== 10'd9) begin tests_failed++; $display("FAIL prog_target got %0d want 9", bus.target); end
    tests_run++; if (bus.incorrect_guesses !== 3'd0) begin tests_failed++; $display("FAIL prog_wrong_clear got %0d want 0", bus.incorrect_guesses); end
    tests_run++; if (bus.hint !== 2'b00) begin tests_failed++; $display("FAIL prog_hint_clear got %b want 00", bus.hint); end
  endtask

  task automatic test_win();
    press(10'd999);
    tests_run++; if (bus.hint !== 2'b10) begin tests_failed++; $display("FAIL out_of_range_hint got %b want 10", bus.hint); end
    tests_run++; if (bus.incorrect_guesses !== 3'd1) begin tests_failed++; $display("FAIL out_of_range_wrong got %0d want 1", bus.incorrect_guesses); end
    win_round();
    win_round();
    win_round();
    tests_run++; if (bus.Max_digit !== 2'b11) begin tests_failed++; $display("FAIL r7_maxdigit got %b want 11", bus.Max_digit); end
    tests_run++; if (bus.timer !== 7'd90) begin tests_failed++; $display("FAIL r7_timer got %0d want 90", bus.timer); end
    tests_run++; if (bus.incorrect_guesses !== 3'd0) begin tests_failed++; $display("FAIL r7_wrong_clear got %0d want 0", bus.incorrect_guesses); end
    press(10'd1023);
    win_round();
    win_round();
    bus.guess         = exp_tgt;
    bus.confirmButton = 1'b1;
    step();
    bus.confirmButton = 1'b0;
    step();
    tests_run++; if (bus.round !== 4'd10) begin tests_failed++; $display("FAIL win_round got %0d want 10", bus.round); end
    bus.WINorLOSE = 2'b10;
    step();
    bus.guess         = exp_tgt ^ 10'd1;
    bus.confirmButton = 1'b1;
    bus.tick_1hz      = 1'b1;
    step();
    bus.confirmButton = 1'b0;
    bus.tick_1hz      = 1'b0;
    step();
    step();
    step();
    tests_run++; if (bus.round !== 4'd10) begin tests_failed++; $display("FAIL halt_round got %0d want 10", bus.round); end
    tests_run++; if (bus.hint !== 2'b11) begin tests_failed++; $display("FAIL halt_hint got %b want 11", bus.hint); end
    tests_run++; if (bus.timer !== 7'd90) begin tests_failed++; $display("FAIL halt_timer got %0d want 90", bus.timer); end
    tests_run++; if (bus.incorrect_guesses !== 3'd1) begin tests_failed++; $display("FAIL halt_wrong got %0d want 1", bus.incorrect_guesses); end
    tests_run++; if (bus.target !== exp_tgt) begin tests_failed++; $display("FAIL halt_target got %0d want %0d", bus.target, exp_tgt); end
  endtask

  task automatic test_countdown();
    do_restart();
    step();
    ticks(15);
    tests_run++; if (bus.timer !== 7'd15) begin tests_failed++; $display("FAIL count_half got %0d want 15", bus.timer); end
    ticks(15);
    tests_run++; if (bus.timer !== 7'd0) begin tests_failed++; $display("FAIL count_zero got %0d want 0", bus.timer); end
    ticks(2);
    tests_run++; if (bus.timer !== 7'd0) begin tests_failed++; $display("FAIL count_nowrap got %0d want 0", bus.timer); end
    bus.WINorLOSE = 2'b00;
    step();
    press(10'd3);
    tests_run++; if (bus.hint !== 2'b00) begin tests_failed++; $display("FAIL lose_hint got %b want 00", bus.hint); end
    tests_run++; if (bus.incorrect_guesses !== 3'd0) begin tests_failed++; $display("FAIL lose_wrong got %0d want 0", bus.incorrect_guesses); end
  endtask

  task automatic test_back_to_back();
    do_restart();
    step();
    ticks(29);
    tests_run++; if (bus.timer !== 7'd1) begin tests_failed++; $display("FAIL sim_timer1 got %0d want 1", bus.timer); end
    bus.guess         = 10'd4;
    bus.confirmButton = 1'b1;
    bus.tick_1hz      = 1'b1;
    step();
    bus.confirmButton = 1'b0;
    bus.tick_1hz      = 1'b0;
    tests_run++; if (bus.timer !== 7'd0) begin tests_failed++; $display("FAIL sim_timer0 got %0d want 0", bus.timer); end
    step();
    tests_run++; if (bus.incorrect_guesses !== 3'd1) begin tests_failed++; $display("FAIL sim_wrong got %0d want 1", bus.incorrect_guesses); end
    tests_run++; if (bus.hint !== 2'b10) begin tests_failed++; $display("FAIL sim_hint got %b want 10", bus.hint); end
    press(10'd0);
    tests_run++; if (bus.round !== 4'd2) begin tests_failed++; $display("FAIL sim_round got %0d want 2", bus.round); end
    // Edge raised during SETTLE and held: must not be judged later.
    bus.guess         = 10'd7;
    bus.confirmButton = 1'b1;
    step();
    step();
    exp_tgt = 10'(seed_m);
    step();
    step();
    tests_run++; if (bus.hint !== 2'b00) begin tests_failed++; $display("FAIL settle_edge_hint got %b want 00", bus.hint); end
    tests_run++; if (bus.incorrect_guesses !== 3'd1) begin tests_failed++; $display("FAIL settle_edge_wrong got %0d want 1", bus.incorrect_guesses); end
    tests_run++; if (bus.timer !== 7'd30) begin tests_failed++; $display("FAIL settle_reload got %0d want 30", bus.timer); end
    tests_run++; if (bus.target !== exp_tgt) begin tests_failed++; $display("FAIL settle_target got %0d want %0d", bus.target, exp_tgt); end
    bus.confirmButton = 1'b0;
    step();
  endtask

  task automatic test_mid_reset();
    do_restart();
    step();
    win_round();
    win_round();
    win_round();
    win_round();
    tests_run++; if (bus.round !== 4'd5) begin tests_failed++; $display("FAIL mid_round5 got %0d want 5", bus.round); end
    do_restart();
    tests_run++; if (bus.round !== 4'd1) begin tests_failed++; $display("FAIL mid_reset_round got %0d want 1", bus.round); end
    tests_run++; if (bus.timer !== 7'd30) begin tests_failed++; $display("FAIL mid_reset_timer got %0d want 30", bus.timer); end
    step();
    tests_run++; if (bus.timer !== 7'd30) begin tests_failed++; $display("FAIL mid_reload_timer got %0d want 30", bus.timer); end
    tests_run++; if (bus.target !== 10'd0) begin tests_failed++; $display("FAIL mid_target got %0d want 0", bus.target); end
  endtask

  initial begin
    restart           = 1'b1;
    bus.WINorLOSE     = 2'b11;
    bus.confirmButton = 1'b0;
    bus.tick_1hz      = 1'b0;
    bus.guess         = 10'd0;
    exp_tgt           = 10'd0;
    test_reset();
    test_wrong_guesses();
    test_progression();
    test_win();
    test_countdown();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d tests", tests_run);
    $fatal(1, "timeout");
  end
endmodule
